// File: rtl/ff_link_pkg.sv
// rtl/ff_link_pkg.sv - shared parameters and FSM state encoding for the ff serial bit link
// Used by the deframer here and by the bridge-side serializer, so both walk the same states.
package ff_link_pkg;

    localparam int FF_ID_W      = 24;
    localparam int FF_MAX_BYTES = 1518;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DISCARD = 2'd3
    } ff_state_t;

endpackage

// File: rtl/ff_bit_deframer_if.sv
// rtl/ff_bit_deframer_if.sv - serial bit input and byte/status output bundle of the deframer
// master: serial source / consumer side (drives ff_en, ff_data; observes byte and status outputs)
// slave : deframer side
//   ff_en, ff_data           serial frame envelope and bit
//   byte_data/valid/last     payload byte stream, one strobe per byte
//   frameid, id_valid        header value and its update strobe
//   frame_ok/err, seq_err    end-of-frame status and sequence-gap strobes
interface ff_bit_deframer_if
    import ff_link_pkg::*;
#(
    parameter int ID_W = FF_ID_W
) ();

    logic            ff_en;
    logic            ff_data;
    logic [7:0]      byte_data;
    logic            byte_valid;
    logic            byte_last;
    logic [ID_W-1:0] frameid;
    logic            id_valid;
    logic            frame_ok;
    logic            frame_err;
    logic            seq_err;

    modport master (
        output ff_en, ff_data,
        input  byte_data, byte_valid, byte_last, frameid, id_valid,
               frame_ok, frame_err, seq_err
    );

    modport slave (
        input  ff_en, ff_data,
        output byte_data, byte_valid, byte_last, frameid, id_valid,
               frame_ok, frame_err, seq_err
    );

endinterface

// File: rtl/ff_shift_byte.sv
// rtl/ff_shift_byte.sv - 8-bit MSB-first serial-to-byte shifter with bit counter
// Ports:
//   clk, resetn     clock, synchronous active-low reset
//   clear           drop any partial byte (counter and shifter to 0)
//   shift_en        take bit_in this cycle
//   bit_in          serial bit
//   byte_next       byte including the current bit; valid when done=1
//   done            combinational strobe: this cycle's bit completes a byte
//   bit_cnt         bits already collected in the current byte
module ff_shift_byte (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       shift_en,
    input  logic       bit_in,
    output logic [7:0] byte_next,
    output logic       done,
    output logic [2:0] bit_cnt
);

    logic [6:0] sh;

    // Completed byte is presented combinationally so the parent can capture it on the
    // same edge that samples the 8th bit; the counter then wraps to 0 by itself.
    assign byte_next = {sh, bit_in};
    assign done      = shift_en && (bit_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            sh      <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            sh      <= {sh[5:0], bit_in};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/ff_bit_deframer.sv
// rtl/ff_bit_deframer.sv - ff serial bit receiver: strips frameid header, packs payload bytes
// Ports:
//   ff_clk    bit clock, all logic on rising edge
//   reset     synchronous active-low reset
//   ff        ff_bit_deframer_if.slave: ff_en/ff_data in; byte_data/valid/last, frameid,
//             id_valid, frame_ok, frame_err, seq_err out (all outputs registered)
module ff_bit_deframer
    import ff_link_pkg::*;
#(
    parameter int MAX_BYTES = FF_MAX_BYTES,
    parameter int ID_W      = FF_ID_W
) (
    input  logic           ff_clk,
    input  logic           reset,
    ff_bit_deframer_if.slave ff
);

    localparam int HDR_BYTES = ID_W / 8;
    localparam int HDR_CW    = $clog2(HDR_BYTES + 1);
    localparam int CNT_W     = $clog2(MAX_BYTES + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BYTES + 1);

    ff_state_t       state;
    logic            wait_low;      // after reset: ignore the line until ff_en is seen low
    logic [HDR_CW-1:0] hdr_cnt;
    logic [CNT_W-1:0]  byte_cnt;
    logic [7:0]      hold_data;
    logic            hold_full;
    logic [ID_W-1:0] id_sh;
    logic            seq_armed;

    logic [7:0]      byte_data_q;
    logic            byte_valid_q;
    logic            byte_last_q;
    logic [ID_W-1:0] frameid_q;
    logic            id_valid_q;
    logic            frame_ok_q;
    logic            frame_err_q;
    logic            seq_err_q;

    logic            shift_en;
    logic [7:0]      sh_byte;
    logic            sh_done;
    logic [2:0]      sh_cnt;
    logic [ID_W-1:0] id_next;

    // The first header bit is taken while still in IDLE, so the shifter runs there too.
    assign shift_en = ff.ff_en && (((state == ST_IDLE) && !wait_low) ||
                                   (state == ST_HDR) || (state == ST_PAYLOAD));
    assign id_next  = (id_sh << 8) | ID_W'(sh_byte);

    ff_shift_byte u_shift (
        .clk       (ff_clk),
        .resetn    (reset),
        .clear     (!ff.ff_en),
        .shift_en  (shift_en),
        .bit_in    (ff.ff_data),
        .byte_next (sh_byte),
        .done      (sh_done),
        .bit_cnt   (sh_cnt)
    );

    always_ff @(posedge ff_clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            wait_low     <= 1'b1;
            hdr_cnt      <= '0;
            byte_cnt     <= '0;
            hold_data    <= '0;
            hold_full    <= 1'b0;
            id_sh        <= '0;
            seq_armed    <= 1'b0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            byte_last_q  <= 1'b0;
            frameid_q    <= '0;
            id_valid_q   <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            byte_last_q  <= 1'b0;
            id_valid_q   <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            seq_err_q    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    hdr_cnt   <= '0;
                    byte_cnt  <= '0;
                    hold_full <= 1'b0;
                    if (wait_low) begin
                        if (!ff.ff_en) wait_low <= 1'b0;
                    end else if (ff.ff_en) begin
                        state <= ST_HDR;
                    end
                end

                ST_HDR: begin
                    if (!ff.ff_en) begin
                        frame_err_q <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (sh_done) begin
                        id_sh   <= id_next;
                        hdr_cnt <= hdr_cnt + HDR_CW'(1);
                        if (hdr_cnt == HDR_CW'(HDR_BYTES - 1)) begin
                            frameid_q  <= id_next;
                            id_valid_q <= 1'b1;
                            // frameid_q still holds the previous header here
                            seq_err_q  <= seq_armed && (id_next != frameid_q + ID_W'(1));
                            seq_armed  <= 1'b1;
                            state      <= ST_PAYLOAD;
                        end
                    end
                end

                ST_PAYLOAD: begin
                    if (!ff.ff_en) begin
                        // With no partial byte the held byte is the frame's final byte.
                        if ((sh_cnt != 3'd0) || (byte_cnt == '0)) begin
                            frame_err_q <= 1'b1;
                        end else begin
                            byte_data_q  <= hold_data;
                            byte_valid_q <= 1'b1;
                            byte_last_q  <= 1'b1;
                            frame_ok_q   <= 1'b1;
                        end
                        hold_full <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (sh_done) begin
                        if (hold_full) begin
                            byte_data_q  <= hold_data;
                            byte_valid_q <= 1'b1;
                        end
                        if (byte_cnt != CNT_MAX) byte_cnt <= byte_cnt + CNT_W'(1);
                        if (byte_cnt == CNT_W'(MAX_BYTES)) begin
                            // Oversize: the overflowing byte never enters the hold register.
                            hold_full <= 1'b0;
                            state     <= ST_DISCARD;
                        end else begin
                            hold_data <= sh_byte;
                            hold_full <= 1'b1;
                        end
                    end
                end

                ST_DISCARD: begin
                    if (!ff.ff_en) begin
                        frame_err_q <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ff.byte_data  = byte_data_q;
    assign ff.byte_valid = byte_valid_q;
    assign ff.byte_last  = byte_last_q;
    assign ff.frameid    = frameid_q;
    assign ff.id_valid   = id_valid_q;
    assign ff.frame_ok   = frame_ok_q;
    assign ff.frame_err  = frame_err_q;
    assign ff.seq_err    = seq_err_q;

endmodule

// File: tb/tb_ff_bit_deframer.sv
// tb/tb_ff_bit_deframer.sv - self-checking bench for ff_bit_deframer
module tb_ff_bit_deframer;

    localparam int MAXB = 4;

    logic ff_clk = 1'b0;
    logic reset  = 1'b0;

    always #5 ff_clk = ~ff_clk;

    ff_bit_deframer_if #(.ID_W(24)) ff ();

    ff_bit_deframer #(.MAX_BYTES(MAXB), .ID_W(24)) dut (
        .ff_clk (ff_clk),
        .reset  (reset),
        .ff     (ff)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] obs_q[$];
    int obs_idv = 0;
    int obs_seq = 0;
    int obs_ok  = 0;
    int obs_err = 0;

    bit          m_armed = 1'b0;
    logic [23:0] m_last  = '0;

    typedef struct {
        logic [23:0] id;
        int          hdr_bits;
        int          pay_bits;
        logic [63:0] pay;
        int          gap;
        int          exp_nb;
        bit          exp_last;
        bit          exp_idv;
        bit          exp_seq;
        bit          exp_ok;
        logic [23:0] exp_fid;
    } vec_t;

    vec_t tbl[9];

    always @(negedge ff_clk) begin
        if (ff.byte_valid) obs_q.push_back({ff.byte_last, ff.byte_data});
        if (ff.id_valid)  obs_idv++;
        if (ff.seq_err)   obs_seq++;
        if (ff.frame_ok)  obs_ok++;
        if (ff.frame_err) obs_err++;
        if (ff.frame_ok || ff.frame_err) begin
            n_checks++;
            if (ff.frame_ok && ff.frame_err) begin
                n_fail++;
                $display("FAIL ok_err_exclusive: frame_ok=1 frame_err=1 required not both");
            end
        end
        if (ff.seq_err) begin
            n_checks++;
            if (!ff.id_valid) begin
                n_fail++;
                $display("FAIL seq_with_id: seq_err=1 id_valid=0 required id_valid=1");
            end
        end
    end

    task automatic tick();
        @(negedge ff_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_idv = 0;
        obs_seq = 0;
        obs_ok  = 0;
        obs_err = 0;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        ff.ff_en   = 1'b0;
        ff.ff_data = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        clear_obs();
        m_armed = 1'b0;
        m_last  = '0;
    endtask

    // Drives the frame bits then one idle cycle; end-of-frame strobes are recorded on return.
    task automatic send_frame(input logic [23:0] id, input int hdr_bits, input int pay_bits,
                              input logic [63:0] pay);
        for (int i = 0; i < hdr_bits; i++) begin
            ff.ff_en = 1'b1; ff.ff_data = id[23-i]; tick();
        end
        for (int i = 0; i < pay_bits; i++) begin
            ff.ff_en = 1'b1; ff.ff_data = pay[63-i]; tick();
        end
        ff.ff_en = 1'b0; ff.ff_data = 1'b0; tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_frame(input string name, input int exp_nb, input logic [63:0] exp_pay,
                               input bit exp_last, input bit exp_idv, input bit exp_seq,
                               input bit exp_ok, input logic [23:0] exp_fid);
        chk({name, ".nbytes"}, 32'(obs_q.size()), 32'(exp_nb));
        for (int i = 0; i < exp_nb && i < obs_q.size(); i++) begin
            logic [7:0] eb;
            eb = exp_pay[63-8*i -: 8];
            chk($sformatf("%s.byte%0d", name, i), {23'd0, obs_q[i]},
                {23'd0, (exp_last && (i == exp_nb - 1)), eb});
        end
        chk({name, ".id_valid"},  32'(obs_idv), 32'(exp_idv));
        chk({name, ".seq_err"},   32'(obs_seq), 32'(exp_seq));
        chk({name, ".frame_ok"},  32'(obs_ok),  32'(exp_ok));
        chk({name, ".frame_err"}, 32'(obs_err), 32'(!exp_ok));
        chk({name, ".frameid"},   32'(ff.frameid), 32'(exp_fid));
        clear_obs();
    endtask

    // Reference: derives the frame outcome from its bit counts and the sequence history.
    task automatic model_frame(input logic [23:0] id, input int hdr_bits, input int pay_bits,
                               output int nb, output bit last, output bit idv,
                               output bit seq, output bit ok);
        logic [23:0] nxt;
        int full;
        nb = 0; last = 0; idv = 0; seq = 0; ok = 0;
        if (hdr_bits >= 24) begin
            nxt     = m_last + 24'd1;
            idv     = 1;
            seq     = m_armed && (id != nxt);
            m_last  = id;
            m_armed = 1'b1;
            full    = pay_bits / 8;
            if (full > MAXB) begin
                nb = MAXB;
            end else if ((pay_bits % 8) != 0 || full == 0) begin
                nb = (full > 0) ? full - 1 : 0;
            end else begin
                nb = full; last = 1; ok = 1;
            end
        end
    endtask

    initial begin
        tbl[0] = '{24'h000001, 24, 16, 64'hA53C_0000_0000_0000, 1, 2, 1, 1, 0, 1, 24'h000001};
        tbl[1] = '{24'h000003, 24,  8, 64'h1100_0000_0000_0000, 3, 1, 1, 1, 1, 1, 24'h000003};
        tbl[2] = '{24'h000004, 24, 12, 64'hABC0_0000_0000_0000, 2, 0, 0, 1, 0, 0, 24'h000004};
        tbl[3] = '{24'h000005, 24, 48, 64'h0102_0304_0506_0000, 2, 4, 0, 1, 0, 0, 24'h000005};
        tbl[4] = '{24'h0000AA, 10,  0, 64'h0,                   2, 0, 0, 0, 0, 0, 24'h000005};
        tbl[5] = '{24'h000006, 24,  0, 64'h0,                   2, 0, 0, 1, 0, 0, 24'h000006};
        tbl[6] = '{24'h000007, 24, 32, 64'hDEAD_BEEF_0000_0000, 2, 4, 1, 1, 0, 1, 24'h000007};
        tbl[7] = '{24'hFFFFFF, 24,  8, 64'h5A00_0000_0000_0000, 1, 1, 1, 1, 1, 1, 24'hFFFFFF};
        tbl[8] = '{24'h000000, 24,  8, 64'hC300_0000_0000_0000, 2, 1, 1, 1, 0, 1, 24'h000000};

        ff.ff_en   = 1'b0;
        ff.ff_data = 1'b0;
        do_reset();
        chk("rst.byte_data",  32'(ff.byte_data),  32'd0);
        chk("rst.byte_valid", 32'(ff.byte_valid), 32'd0);
        chk("rst.byte_last",  32'(ff.byte_last),  32'd0);
        chk("rst.frameid",    32'(ff.frameid),    32'd0);
        chk("rst.id_valid",   32'(ff.id_valid),   32'd0);
        chk("rst.frame_ok",   32'(ff.frame_ok),   32'd0);
        chk("rst.frame_err",  32'(ff.frame_err),  32'd0);
        chk("rst.seq_err",    32'(ff.seq_err),    32'd0);

        for (int i = 0; i < 9; i++) begin
            send_frame(tbl[i].id, tbl[i].hdr_bits, tbl[i].pay_bits, tbl[i].pay);
            check_frame($sformatf("tbl%0d", i), tbl[i].exp_nb, tbl[i].pay, tbl[i].exp_last,
                        tbl[i].exp_idv, tbl[i].exp_seq, tbl[i].exp_ok, tbl[i].exp_fid);
            idle(tbl[i].gap - 1);
        end

        // Reset pulse in the middle of a payload while ff_en stays high.
        for (int i = 0; i < 24; i++) begin
            ff.ff_en = 1'b1; ff.ff_data = (i == 20); tick();
        end
        for (int i = 0; i < 5; i++) begin
            ff.ff_en = 1'b1; ff.ff_data = 1'b1; tick();
        end
        clear_obs();
        reset = 1'b0; ff.ff_en = 1'b1; ff.ff_data = 1'b1; tick();
        chk("rstmid.byte_data",  32'(ff.byte_data),  32'd0);
        chk("rstmid.frameid",    32'(ff.frameid),    32'd0);
        chk("rstmid.strobes",
            32'({ff.byte_valid, ff.byte_last, ff.id_valid, ff.frame_ok, ff.frame_err, ff.seq_err}),
            32'd0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ff.ff_en = 1'b1; ff.ff_data = 1'($urandom); tick();
        end
        ff.ff_en = 1'b0; tick();
        chk("rstmid.quiet", 32'(obs_q.size() + obs_idv + obs_ok + obs_err + obs_seq), 32'd0);
        send_frame(24'h000005, 24, 8, 64'h7700_0000_0000_0000);
        check_frame("rstmid.next", 1, 64'h7700_0000_0000_0000, 1, 1, 0, 1, 24'h000005);
        idle(2);

        // Randomized frames against the reference model.
        do_reset();
        for (int f = 0; f < 40; f++) begin
            logic [23:0] id;
            logic [63:0] pay;
            int hdr_bits, pay_bits, nb;
            bit last, idv, seq, ok;
            case ($urandom % 4)
                0, 1:    id = m_last + 24'd1;
                2:       id = m_last;
                default: id = 24'($urandom);
            endcase
            pay = {$urandom, $urandom};
            if ($urandom % 8 == 0) begin
                hdr_bits = $urandom_range(1, 23);
                pay_bits = 0;
            end else begin
                hdr_bits = 24;
                pay_bits = 8 * $urandom_range(0, 6);
                if ($urandom % 3 == 0) pay_bits += $urandom_range(1, 7);
            end
            model_frame(id, hdr_bits, pay_bits, nb, last, idv, seq, ok);
            send_frame(id, hdr_bits, pay_bits, pay);
            check_frame($sformatf("rnd%0d", f), nb, pay, last, idv, seq, ok, m_last);
            idle($urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
